rv32_debug_host: RTL and testbench
==================================

# rv32_debug_host

Host-side controller for the RV32core debug port. It drives the core's debug inputs (`debug_en`, `debug_step`, `debug_addr`) and captures `debug_data`. It accepts simple commands (halt, run, single-step, dump a range of debug addresses) and streams each captured word on a valid/ready output. It sits between a UART/VGA front-end or testbench and the core, and replaces the tied-off debug inputs used in simulation.

## Interface
- `ADDR_W`, 7, debug address width.
- `DATA_W`, 32, debug data width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  2  00 HALT, 01 RUN, 10 STEP, 11 DUMP.
- `cmd_lo`  in  ADDR_W  first dump address (DUMP only).
- `cmd_hi`  in  ADDR_W  last dump address, inclusive (DUMP only).
- `debug_en`  out  1  to core; 1 = core halted under debug control.
- `debug_step`  out  1  to core; one-cycle step pulse.
- `debug_addr`  out  ADDR_W  to core; registered.
- `debug_data`  in  DATA_W  from core; valid one cycle after `debug_addr` changes.
- `out_valid`  out  1  captured word available.
- `out_ready`  in  1  consumer accepts word.
- `out_addr`  out  ADDR_W  address of captured word.
- `out_data`  out  DATA_W  captured word.
- `out_last`  out  1  word is the one at `cmd_hi`.
- `busy`  out  1  not in IDLE.

## Operation
- States: IDLE, STEP, SET, CAP, OUT.
- Command accepted on a cycle with `cmd_valid && cmd_ready`. Operands `cmd_op`, `cmd_lo` and `cmd_hi` are latched at accept.
- **HALT:** set `debug_en`=1. Stay in IDLE.
- **RUN:** clear `debug_en`=0. Stay in IDLE.
- **STEP:**
  - If `debug_en`=0: no-op, stay in IDLE.
  - Otherwise go to STEP. Assert `debug_step`=1 for exactly one cycle, then return to IDLE.
- **DUMP:**
  - `debug_en` is left unchanged. Dumping while running is legal but the values are not coherent.
  - Load `debug_addr`←`cmd_lo` and go to SET.
  - SET: one settle cycle, then go to CAP.
  - CAP: register `out_data`←`debug_data` and `out_addr`←`debug_addr`. Set `out_last`=(`debug_addr`==hi). Raise `out_valid`. Go to OUT.
  - OUT: hold all outputs stable until `out_ready`.
    - On handshake with `out_last`=0: `debug_addr`+1, go to SET.
    - On handshake with `out_last`=1: go to IDLE.
  - The address increments modulo 2^ADDR_W.
- **lo > hi:** the sweep wraps through 2^ADDR_W−1 to 0 and ends at hi. Number of words = ((hi−lo) mod 2^ADDR_W)+1.
- **lo == hi:** exactly one word, with `out_last`=1.
- Commands arriving while `busy` are not accepted; `cmd_ready`=0. The source must hold them.

## Timing
- **Reset values** (asynchronous, on `rst`=0): state IDLE, `debug_en`=0, `debug_step`=0, `debug_addr`=0, `out_valid`=0, `out_addr`=0, `out_data`=0, `out_last`=0, `busy`=0, `cmd_ready`=1.
- **Reset mid-DUMP or mid-STEP:** all outputs return to the reset values immediately. A pending word is discarded. No partial step pulse survives.
- **HALT/RUN:** `debug_en` changes on the clock edge that accepts the command (visible the next cycle). Zero busy cycles.
- **STEP:** `debug_step` is high in the cycle after accept, low after that. `cmd_ready` is low for that one cycle.
- **DUMP latency:**
  - Accept at edge T. `debug_addr`=lo from T+1.
  - Captured at edge T+2. `out_valid`=1 from T+2.
- **Per-word throughput:** 3 cycles with `out_ready` held at 1. Handshake edge H, new `debug_addr` from H+1, next `out_valid` from H+2.
- `out_valid` never drops without a handshake. `out_*` never change while `out_valid`=1 and `out_ready`=0.
- `debug_addr` only changes at command accept or on an OUT handshake.

## Test plan
- **Reset and HALT:**
  - Hold `rst`=0 for 3 cycles: all outputs at reset values, `cmd_ready`=1.
  - Then HALT: `debug_en`=1 the next cycle, `busy` never asserted.
- **STEP:**
  - STEP while halted: `debug_step` high for exactly 1 cycle, the cycle after accept. `cmd_ready`=0 that cycle only.
  - STEP after RUN: `debug_step` stays 0.
- **Full DUMP with no back-pressure:**
  - Halt the core, DUMP lo=0, hi=3, `out_ready`=1.
  - Expect 4 words with `out_addr` 0,1,2,3. Words are 3 cycles apart. `out_last` only on addr 3. `out_data` equals the core's debug value for each address.
- **Back-pressure:**
  - DUMP lo=5, hi=6. Hold `out_ready`=0 for 10 cycles on the first word.
  - `out_valid`, `out_addr`=5 and `out_data` stay stable throughout. `debug_addr` stays 5.
  - Release: the second word (addr 6, `out_last`=1) follows 2 cycles after the handshake.
- **Wrap and single-word ranges:**
  - DUMP lo=126, hi=1: `out_addr` sequence 126,127,0,1, `out_last` on 1.
  - DUMP lo=hi=9: one word, `out_last`=1.
- **Reset mid-DUMP:**
  - Assert `rst`=0 while in OUT: `out_valid` drops immediately, `debug_addr`=0, `debug_en`=0.
  - After release: `cmd_ready`=1, and a new DUMP works normally.

Source files
------------

// File: rtl/rv32_debug_host.sv
// Host-side debug controller for the RV32 core: halts, runs and single-steps the core,
// and sweeps a range of debug addresses, streaming each captured word on a valid/ready port.
module rv32_debug_host #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_lo,
  input  logic [ADDR_W-1:0] cmd_hi,
  output logic              debug_en,
  output logic              debug_step,
  output logic [ADDR_W-1:0] debug_addr,
  input  logic [DATA_W-1:0] debug_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam logic [1:0] OP_HALT = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP,
    S_SET,
    S_CAP,
    S_OUT
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] hi_q;

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // SET gives the core's registered debug_data a cycle to follow debug_addr before CAP samples it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      hi_q       <= '0;
      debug_en   <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= '0;
      out_valid  <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      debug_step <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              OP_HALT: debug_en <= 1'b1;
              OP_RUN:  debug_en <= 1'b0;
              OP_STEP: begin
                if (debug_en) begin
                  debug_step <= 1'b1;
                  state      <= S_STEP;
                end
              end
              OP_DUMP: begin
                debug_addr <= cmd_lo;
                hi_q       <= cmd_hi;
                state      <= S_SET;
              end
              default: state <= S_IDLE;
            endcase
          end
        end
        S_STEP: state <= S_IDLE;
        S_SET:  state <= S_CAP;
        S_CAP: begin
          out_data  <= debug_data;
          out_addr  <= debug_addr;
          out_last  <= (debug_addr == hi_q);
          out_valid <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          // The address wraps naturally at 2^ADDR_W, which is what makes lo > hi sweeps work.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              state <= S_IDLE;
            end else begin
              debug_addr <= debug_addr + ADDR_W'(1);
              state      <= S_SET;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_debug_host.sv
// Self-checking bench for rv32_debug_host: a register-file model stands in for the core,
// and each dump is checked against the word list expected from the command's address range.
module tb_rv32_debug_host;

  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_lo = '0;
  logic [AW-1:0] cmd_hi = '0;
  logic          debug_en;
  logic          debug_step;
  logic [AW-1:0] debug_addr;
  logic [DW-1:0] debug_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic [DW-1:0] core_mem [128];

  rv32_debug_host #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_lo(cmd_lo), .cmd_hi(cmd_hi),
    .debug_en(debug_en), .debug_step(debug_step),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // The core presents the addressed debug word one cycle after the address changes.
  always @(posedge clk) debug_data <= core_mem[debug_addr];

  task automatic refill_core();
    for (int i = 0; i < 128; i++) core_mem[i] = $urandom;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
    int waitc = 0;
    cmd_op = op; cmd_lo = lo; cmd_hi = hi; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && waitc < 100) begin
      @(posedge clk); #1; waitc++;
    end
    n_cmp++;
    if (waitc >= 100) begin
      n_fail++; $display("[TB] FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_dump(input logic [AW-1:0] lo, input logic [AW-1:0] hi, input int pct, input int hold_first);
    word_t exp[$];
    word_t w;
    int n, gap, budget, hold;
    bit seen;
    refill_core();
    n = ((int'(hi) - int'(lo) + 128) % 128) + 1;
    for (int k = 0; k < n; k++) begin
      w.addr = AW'((int'(lo) + k) % 128);
      w.data = core_mem[(int'(lo) + k) % 128];
      w.last = (k == n - 1);
      exp.push_back(w);
    end
    out_ready = 1'b0;
    send_cmd(2'b11, lo, hi);
    gap = 0; budget = 0; hold = hold_first; seen = 0;
    while (exp.size() > 0 && budget < 3000) begin
      if (out_valid === 1'b1) begin
        if (!seen) begin
          n_cmp++;
          if (gap != 2) begin
            n_fail++; $display("[TB] FAIL word_latency addr %0d: %0d cycles, required 2", exp[0].addr, gap);
          end
          seen = 1;
        end
        n_cmp++;
        if ({out_addr, out_data, out_last} !== {exp[0].addr, exp[0].data, exp[0].last}) begin
          n_fail++;
          $display("[TB] FAIL dump_word: addr=%0d data=%h last=%b, required addr=%0d data=%h last=%b",
                   out_addr, out_data, out_last, exp[0].addr, exp[0].data, exp[0].last);
        end
        n_cmp++;
        if (debug_addr !== exp[0].addr) begin
          n_fail++; $display("[TB] FAIL debug_addr_hold: %0d, required %0d", debug_addr, exp[0].addr);
        end
        if (hold > 0) begin
          out_ready = 1'b0; hold--;
        end else begin
          out_ready = ($urandom_range(0, 99) < pct);
        end
        if (out_ready) begin
          void'(exp.pop_front());
          seen = 0; gap = -1;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        n_cmp++;
        if (busy !== 1'b1) begin
          n_fail++; $display("[TB] FAIL busy_during_dump: %b, required 1", busy);
        end
      end
      @(posedge clk); #1;
      gap++; budget++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (exp.size() != 0) begin
      n_fail++; $display("[TB] FAIL dump_timeout: %0d words missing, required 0", exp.size());
    end
    n_cmp++;
    if ({out_valid, busy, cmd_ready} !== 3'b001) begin
      n_fail++; $display("[TB] FAIL dump_end: valid/busy/ready=%b, required 001", {out_valid, busy, cmd_ready});
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({debug_en, debug_step, debug_addr} !== {1'b0, 1'b0, 7'd0}) begin
      n_fail++; $display("[TB] FAIL reset_debug: en=%b step=%b addr=%0d, required 0 0 0", debug_en, debug_step, debug_addr);
    end
    n_cmp++;
    if ({out_valid, out_addr, out_data, out_last} !== {1'b0, 7'd0, 32'd0, 1'b0}) begin
      n_fail++; $display("[TB] FAIL reset_out: valid=%b addr=%0d data=%h last=%b, required all 0", out_valid, out_addr, out_data, out_last);
    end
    n_cmp++;
    if ({busy, cmd_ready} !== 2'b01) begin
      n_fail++; $display("[TB] FAIL reset_status: busy=%b cmd_ready=%b, required 0 1", busy, cmd_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_halt();
    send_cmd(2'b00, '0, '0);
    n_cmp++;
    if ({debug_en, busy} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL halt: en=%b busy=%b, required 1 0", debug_en, busy);
    end
  endtask

  task automatic test_step();
    send_cmd(2'b10, '0, '0);
    n_cmp++;
    if ({debug_step, cmd_ready, busy} !== 3'b101) begin
      n_fail++; $display("[TB] FAIL step_pulse: step/ready/busy=%b, required 101", {debug_step, cmd_ready, busy});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({debug_step, cmd_ready, debug_en} !== 3'b011) begin
      n_fail++; $display("[TB] FAIL step_end: step/ready/en=%b, required 011", {debug_step, cmd_ready, debug_en});
    end
    send_cmd(2'b01, '0, '0);
    n_cmp++;
    if (debug_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL run: en=%b, required 0", debug_en);
    end
    send_cmd(2'b10, '0, '0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({debug_step, busy} !== 2'b00) begin
        n_fail++; $display("[TB] FAIL step_while_running: step=%b busy=%b, required 0 0", debug_step, busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_dump();
    int waitc = 0;
    send_cmd(2'b00, '0, '0);
    out_ready = 1'b0;
    send_cmd(2'b11, 7'd20, 7'd40);
    while (out_valid !== 1'b1 && waitc < 20) begin
      @(posedge clk); #1; waitc++;
    end
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL mid_dump_valid: %b, required 1", out_valid);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, debug_addr, debug_en, busy, cmd_ready} !== {1'b0, 7'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("[TB] FAIL reset_mid_dump: valid=%b addr=%0d en=%b busy=%b ready=%b, required 0 0 0 0 1",
                         out_valid, debug_addr, debug_en, busy, cmd_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({cmd_ready, out_valid} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL after_reset: ready=%b valid=%b, required 1 0", cmd_ready, out_valid);
    end
    run_dump(7'd40, 7'd43, 70, 0);
  endtask

  task automatic test_random_dumps();
    logic [AW-1:0] lo, hi;
    for (int i = 0; i < 6; i++) begin
      lo = AW'($urandom_range(0, 127));
      hi = lo + AW'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) send_cmd(2'b00, '0, '0);
      run_dump(lo, hi, 50, 0);
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(2'b00, '0, '0);
    run_dump(7'd100, 7'd101, 100, 0);
    run_dump(7'd102, 7'd102, 100, 0);
    send_cmd(2'b10, '0, '0);
    n_cmp++;
    if (debug_step !== 1'b1) begin
      n_fail++; $display("[TB] FAIL step_after_dump: %b, required 1", debug_step);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    refill_core();
    test_reset();
    test_halt();
    test_step();
    send_cmd(2'b00, '0, '0);
    run_dump(7'd0, 7'd3, 100, 0);
    run_dump(7'd5, 7'd6, 100, 10);
    run_dump(7'd126, 7'd1, 100, 0);
    run_dump(7'd9, 7'd9, 100, 0);
    test_reset_mid_dump();
    test_random_dumps();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
